// File: rtl/pc_sequencer.sv
// Fetch-address sequencer: sequential advance, branch/jump redirect, hazard stalls.
// Define PC_SEQ_EXC_EN to build the exception path (exc_req, epc_out, EXC state).
module pc_sequencer #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned STALL_CYCLES = 2,
    parameter logic [31:0] EXC_VECTOR   = 32'h8000_0180
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall_req,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_req,
    input  logic [31:0] jump_target,
    input  logic        exc_req,
    output logic [31:0] pc_out,
    output logic [31:0] epc_out,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        stalled
);

`ifdef PC_SEQ_EXC_EN
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1, EXC = 2'd2} state_t;
`else
    typedef enum logic [1:0] {RUN = 2'd0, STALL = 2'd1} state_t;
`endif

    localparam logic [3:0] STALL_RELOAD = 4'(STALL_CYCLES - 1);

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        flush_ifid, flush_idex;
    logic        take_exc, take_br, take_jmp;
    logic [31:0] seq_pc;

`ifdef PC_SEQ_EXC_EN
    logic [31:0] epc_q, epc_d;
    assign take_exc = exc_req;
    assign take_br  = branch_taken && (state_q != EXC);
`else
    logic unused_exc;
    assign unused_exc = exc_req;
    assign take_exc   = 1'b0;
    assign take_br    = branch_taken;
`endif
    // Jumps are dropped while stalled; the decoder re-presents them afterwards.
    assign take_jmp = jump_req && (state_q == RUN);
    assign seq_pc   = pc_q + 32'd4;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
`ifdef PC_SEQ_EXC_EN
        epc_d      = epc_q;
`endif
        flush_ifid = 1'b0;
        flush_idex = (state_q == STALL);
        if (take_exc) begin
`ifdef PC_SEQ_EXC_EN
            epc_d      = pc_q;
            pc_d       = EXC_VECTOR;
            cnt_d      = 4'd0;
            state_d    = EXC;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
`endif
        end else if (take_br) begin
            pc_d       = {branch_target[31:2], 2'b00};
            cnt_d      = 4'd0;
            state_d    = RUN;
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (take_jmp) begin
            pc_d       = {jump_target[31:2], 2'b00};
            flush_ifid = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (stall_req) begin
                        cnt_d   = STALL_RELOAD;
                        state_d = STALL;
                    end else begin
                        pc_d = seq_pc;
                    end
                end
                STALL: begin
                    // A new request restarts the count rather than adding to it.
                    if (stall_req) begin
                        cnt_d = STALL_RELOAD;
                    end else if (cnt_q == 4'd0) begin
                        pc_d    = seq_pc;
                        state_d = RUN;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
`ifdef PC_SEQ_EXC_EN
                EXC: begin
                    flush_ifid = 1'b1;
                    flush_idex = 1'b1;
                    pc_d       = seq_pc;
                    state_d    = RUN;
                end
`endif
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PC_SEQ_EXC_EN
    always_ff @(posedge clk) begin
        if (!reset_n) epc_q <= 32'd0;
        else          epc_q <= epc_d;
    end
    assign epc_out = epc_q;
`else
    assign epc_out = 32'd0;
`endif

    assign pc_out      = pc_q;
    assign if_id_flush = !reset_n || flush_ifid;
    assign id_ex_flush = !reset_n || flush_idex;
    assign stalled     = reset_n && (state_q == STALL);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed + random bench for pc_sequencer against a cycle-level behavioural model.
module tb_pc_sequencer;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          SC       = 2;
    localparam logic [31:0] VEC      = 32'h8000_0180;
`ifdef PC_SEQ_EXC_EN
    localparam bit EXC_EN = 1'b1;
`else
    localparam bit EXC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n, stall_req, branch_taken, jump_req, exc_req;
    logic [31:0] branch_target, jump_target;
    logic [31:0] pc_out, epc_out;
    logic        if_id_flush, id_ex_flush, stalled;

    int nvec = 0;
    int nerr = 0;

    // Model: PC, captured EPC, whether we are stalled and how many stall cycles remain.
    logic [31:0] m_pc, m_epc;
    bit          m_stall, m_exc;
    int          m_left;

    pc_sequencer #(.RESET_PC(RESET_PC), .STALL_CYCLES(SC), .EXC_VECTOR(VEC)) dut (
        .clk(clk), .reset_n(reset_n), .stall_req(stall_req),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .jump_req(jump_req), .jump_target(jump_target), .exc_req(exc_req),
        .pc_out(pc_out), .epc_out(epc_out), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .stalled(stalled)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_epc = 32'd0; m_stall = 0; m_exc = 0; m_left = 0;
    endtask

    // One clock: drive at negedge, check outputs, advance the model on the edge.
    task automatic step(input bit rst, input bit st, input bit br, input logic [31:0] bt,
                        input bit jp, input logic [31:0] jt, input bit ex);
        logic e_ifid, e_idex, e_stl;
        reset_n = rst; stall_req = st; branch_taken = br; branch_target = bt;
        jump_req = jp; jump_target = jt; exc_req = ex;
        #1;
        e_stl = rst && m_stall;
        if (!rst) begin
            e_ifid = 1; e_idex = 1;
        end else if ((EXC_EN && ex) || m_exc || br) begin
            e_ifid = 1; e_idex = 1;
        end else begin
            e_ifid = jp && !m_stall;
            e_idex = m_stall;
        end
        chk("pc", pc_out, m_pc);
        chk("epc", epc_out, m_epc);
        chk("if_id_flush", {31'd0, if_id_flush}, {31'd0, e_ifid});
        chk("id_ex_flush", {31'd0, id_ex_flush}, {31'd0, e_idex});
        chk("stalled", {31'd0, stalled}, {31'd0, e_stl});
        @(posedge clk);
        if (!rst) model_reset();
        else if (EXC_EN && ex) begin
            m_epc = m_pc; m_pc = VEC; m_exc = 1; m_stall = 0;
        end else if (m_exc) begin
            m_pc = m_pc + 32'd4; m_exc = 0;
        end else if (br) begin
            m_pc = bt & ~32'h3; m_stall = 0;
        end else if (jp && !m_stall) begin
            m_pc = jt & ~32'h3;
        end else if (st) begin
            m_stall = 1; m_left = SC;
        end else if (m_stall) begin
            m_left--;
            if (m_left == 0) begin
                m_stall = 0; m_pc = m_pc + 32'd4;
            end
        end else begin
            m_pc = m_pc + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic idle();
        step(1, 0, 0, 32'd0, 0, 32'd0, 0);
    endtask

    initial begin
        reset_n = 0; stall_req = 0; branch_taken = 0; jump_req = 0; exc_req = 0;
        branch_target = 0; jump_target = 0;
        @(posedge clk); @(negedge clk);
        model_reset();
        step(0, 1, 1, 32'h44, 1, 32'h88, 1);  // reset overrides everything
        chk("rst_pc", pc_out, RESET_PC);

        // Sequential fetch 0,4,8 then a one-cycle stall at 8.
        idle(); idle();
        chk("seq_pc8", pc_out, 32'd8);
        step(1, 1, 0, 32'd0, 0, 32'd0, 0);
        chk("stall_hold1", pc_out, 32'd8);
        chk("stall_on", {31'd0, stalled}, 32'd1);
        idle();
        chk("stall_hold2", pc_out, 32'd8);
        idle();
        chk("stall_exit", pc_out, 32'd12);
        chk("stall_off", {31'd0, stalled}, 32'd0);

        // Branch aborts a stall; target low bits cleared.
        step(1, 1, 0, 32'd0, 0, 32'd0, 0);
        step(1, 0, 1, 32'h0000_0103, 0, 32'd0, 0);
        chk("br_in_stall", pc_out, 32'h100);

        // Jump in STALL is ignored; reload does not accumulate.
        step(1, 1, 0, 32'd0, 0, 32'd0, 0);
        step(1, 1, 0, 32'd0, 1, 32'h400, 0);
        step(1, 0, 0, 32'd0, 1, 32'h400, 0);
        step(1, 0, 0, 32'd0, 0, 32'd0, 0);
        chk("stall_reload", pc_out, 32'h104);

        // Branch beats jump.
        step(1, 0, 1, 32'h80, 1, 32'h40, 0);
        chk("br_over_jmp", pc_out, 32'h80);

        // Exception at 0x20.
        step(1, 0, 0, 32'd0, 1, 32'h20, 0);
        step(1, 0, 0, 32'd0, 0, 32'd0, 1);
        if (EXC_EN) begin
            chk("exc_vec", pc_out, VEC);
            chk("exc_epc", epc_out, 32'h20);
            idle();
            chk("exc_exit", pc_out, VEC + 32'd4);
        end else begin
            chk("exc_off", pc_out, 32'h24);
        end
        idle();

        // Wrap at the top of the address space.
        step(1, 0, 0, 32'd0, 1, 32'hFFFF_FFFE, 0);
        chk("jmp_top", pc_out, 32'hFFFF_FFFC);
        idle();
        chk("wrap", pc_out, 32'd0);

        // Reset in the middle of a stall.
        idle(); idle();
        step(1, 1, 0, 32'd0, 0, 32'd0, 0);
        step(0, 0, 0, 32'd0, 0, 32'd0, 0);
        chk("rst_mid_stall", pc_out, RESET_PC);
        chk("rst_run", {31'd0, stalled}, 32'd0);

        for (int i = 0; i < 500; i++) begin
            step(($urandom % 40) != 0, ($urandom % 4) == 0, ($urandom % 8) == 0, $urandom,
                 ($urandom % 6) == 0, $urandom, ($urandom % 10) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded at reset.
REQ-002 Parameter STALL_CYCLES, default 2: number of cycles the PC holds per accepted stall request; legal range 1..15.
REQ-003 Parameter EXC_VECTOR, default 32'h8000_0180: exception handler address.
REQ-004 clk  in  1: single clock; all state updates on rising edge.
REQ-005 reset_n  in  1: synchronous, active-low reset.
REQ-006 stall_req  in  1: load-use hazard request from the hazard unit.
REQ-007 branch_taken  in  1 / branch_target  in  32: resolved taken branch and its target.
REQ-008 jump_req  in  1 / jump_target  in  32: decoded jump and its target.
REQ-009 exc_req  in  1: exception request (used only when the exception feature is compiled in).
REQ-010 pc_out  out  32: current fetch address, registered.
REQ-011 epc_out  out  32: PC captured at the last accepted exception, registered.
REQ-012 if_id_flush  out  1 / id_ex_flush  out  1: combinational pipeline-register flush strobes.
REQ-013 stalled  out  1: high while the state is STALL.

Function
REQ-014 The block SHALL implement the states RUN, STALL and EXC, with a 4-bit stall counter.
REQ-015 The next-PC priority in any state SHALL be exc_req > branch_taken > jump_req > stall_req > sequential.
REQ-016 exc_req SHALL load pc_out with EXC_VECTOR, load epc_out with the current pc_out, assert both flushes and enter EXC.
REQ-017 branch_taken SHALL load pc_out with {branch_target[31:2],2'b00}, assert if_id_flush and id_ex_flush, and enter RUN.
REQ-018 jump_req SHALL load pc_out with {jump_target[31:2],2'b00}, assert if_id_flush only, and enter RUN.
REQ-019 stall_req in RUN SHALL hold pc_out, load the counter with STALL_CYCLES-1 and enter STALL.
REQ-020 With no request in RUN, pc_out SHALL advance by 4 modulo 2^32 (32'hFFFF_FFFC wraps to 32'h0000_0000).
REQ-021 In STALL, pc_out SHALL hold and id_ex_flush SHALL be asserted every cycle (bubble insertion).
REQ-022 In STALL, the counter SHALL decrement each cycle; when it is 0 with no request, the state SHALL return to RUN and pc_out SHALL advance by 4 on that edge.
REQ-023 stall_req in STALL SHALL reload the counter with STALL_CYCLES-1; it SHALL NOT extend the stall cumulatively.
REQ-024 jump_req in STALL SHALL be ignored (the jump is re-presented after the stall); branch_taken or exc_req in STALL SHALL abort the stall per REQ-016/017.
REQ-025 EXC SHALL last exactly one cycle with pc_out held and both flushes asserted, then go to RUN; only a new exc_req is honoured in EXC.
REQ-026 Flush outputs SHALL be combinational from the state and the inputs in the same cycle as the redirect; they SHALL be 0 when there is no redirect and the state is not STALL.

Reset
REQ-027 When reset_n=0 at a rising edge: pc_out=RESET_PC, epc_out=0, state=RUN, counter=0; reset SHALL override every request, including mid-stall and in EXC.
REQ-028 While reset_n=0, if_id_flush and id_ex_flush SHALL be 1 and stalled SHALL be 0.

Configuration
REQ-029 Macro PC_SEQ_EXC_EN defined: exc_req, epc_out and the EXC state SHALL be implemented as specified.
REQ-030 PC_SEQ_EXC_EN undefined: exc_req SHALL be ignored, epc_out SHALL be tied to 0, the EXC state SHALL NOT exist, and the ports SHALL remain present.

Verification
REQ-031 Release reset with no requests -> pc_out sequence 0,4,8,12; all flushes 0 after reset.
REQ-032 Raise stall_req for 1 cycle at pc_out=8 (STALL_CYCLES=2) -> pc_out=8 for 3 cycles, stalled high 2 cycles, id_ex_flush high 2 cycles, then pc_out=12.
REQ-033 In STALL, raise branch_taken with target 32'h0000_0103 -> next pc_out=32'h0000_0100, both flushes high that cycle, stalled drops.
REQ-034 Raise jump_req and branch_taken together (jump_target=0x40, branch_target=0x80) -> pc_out=0x80, id_ex_flush=1.
REQ-035 With PC_SEQ_EXC_EN defined, raise exc_req at pc_out=0x20 -> pc_out=0x80000180, epc_out=0x20, one EXC cycle, then 0x80000184; with the macro undefined, the same stimulus -> pc_out=0x24.
REQ-036 Force pc_out=32'hFFFF_FFFC via jump -> next pc_out=0; assert reset_n=0 mid-STALL -> pc_out=RESET_PC and state RUN on the next edge.
